// File: rtl/inst_packer.sv
// Packs R/J-format field tuples into 24-bit instruction words and streams them
// through a small FIFO into instruction memory at consecutive addresses.
module inst_packer #(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic          jfmt,
    input  logic [5:0]    opc,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [2:0]    funcode,
    input  logic [17:0]   jba,
    input  logic          mem_busy,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [23:0]   imem_wdata,
    output logic          done,
    output logic [AW:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_OCC = (PW + 1)'(DEPTH);
    localparam logic [PW:0] ONE_OCC  = (PW + 1)'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [23:0]   fifo_mem [DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic [PW:0]   occ;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic [23:0]   packed_word;
    logic [AW-1:0] addr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign occ   = wr_ptr - rd_ptr;
    assign empty = (occ == '0);
    assign full  = (occ == FULL_OCC);

    assign in_ready = (state == RUN) && !full;
    assign push     = in_valid && in_ready;
    assign pop      = imem_we;

    assign packed_word = jfmt ? {opc, jba} : {opc, rs, rt, 5'b00000, funcode};

    assign imem_we    = !empty && !mem_busy;
    assign imem_addr  = addr;
    assign imem_wdata = fifo_mem[rd_ptr[PW-1:0]];

    // Only DRAIN can pop its final entry, since no push happens outside RUN.
    assign done = (state == DRAIN) && pop && (occ == ONE_OCC);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (push && in_last) state_nxt = DRAIN;
            DRAIN:   if (done || empty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            addr   <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + ONE_OCC;
            if (pop)  rd_ptr <= rd_ptr + ONE_OCC;
            if (state == IDLE && start) begin
                addr  <= base_addr;
                count <= '0;
            end else if (pop) begin
                addr  <= addr + AW'(1);
                count <= count + (AW + 1)'(1);
            end
        end
    end

    // Storage needs no reset: occupancy comes solely from the pointers.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PW-1:0]] <= packed_word;
    end

endmodule

// File: tb/tb_inst_packer.sv
// Directed self-checking bench for inst_packer: packing formats, backpressure,
// address wrap, ignored start, and mid-session reset.
module tb_inst_packer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  base_addr;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic        jfmt;
    logic [5:0]  opc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [2:0]  funcode;
    logic [17:0] jba;
    logic        mem_busy;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [23:0] imem_wdata;
    logic        done;
    logic [8:0]  count;

    int checks   = 0;
    int failures = 0;
    int doneCnt  = 0;
    logic [7:0]  wAddr [$];
    logic [23:0] wData [$];
    logic [7:0]  expA [8];
    logic [23:0] expD [8];

    inst_packer #(.DEPTH(4), .AW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .jfmt(jfmt), .opc(opc), .rs(rs), .rt(rt), .funcode(funcode), .jba(jba),
        .mem_busy(mem_busy), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .done(done), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write/done monitor sampled on the falling edge, away from state updates.
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            wAddr.push_back(imem_addr);
            wData.push_back(imem_wdata);
        end
        if (rst_n && done) doneCnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clearLog();
        wAddr.delete();
        wData.delete();
        doneCnt = 0;
    endtask

    task automatic driveTuple(input logic jf, input logic [5:0] o, input logic [4:0] s,
                              input logic [4:0] t, input logic [2:0] f,
                              input logic [17:0] j, input logic last);
        jfmt = jf; opc = o; rs = s; rt = t; funcode = f; jba = j; in_last = last;
        in_valid = 1'b1;
    endtask

    // Callers are always positioned 1 time unit after a rising edge.
    task automatic applyStimulus(input logic jf, input logic [5:0] o, input logic [4:0] s,
                                 input logic [4:0] t, input logic [2:0] f,
                                 input logic [17:0] j, input logic last);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        driveTuple(jf, o, s, t, f, j, last);
        while (!acc && n < 40) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic startSession(input logic [7:0] b);
        clearLog();
        start = 1'b1;
        base_addr = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = done;
        end
        @(posedge clk);
        #1;
        if (!got) checkOutput("done_timeout", 32'd0, 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic checkSession(input string tag, input int n);
        checkOutput($sformatf("%s_nwrites", tag), wAddr.size(), n);
        for (int i = 0; i < n && i < wAddr.size(); i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), {24'd0, wAddr[i]}, {24'd0, expA[i]});
            checkOutput($sformatf("%s_data%0d", tag, i), {8'd0, wData[i]}, {8'd0, expD[i]});
        end
        checkOutput($sformatf("%s_done", tag), doneCnt, 1);
        checkOutput($sformatf("%s_count", tag), {23'd0, count}, n);
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
        jfmt = 1'b0; opc = '0; rs = '0; rt = '0; funcode = '0; jba = '0; mem_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_imem_we", imem_we, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_count", count, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Tuples offered in IDLE must be refused and never written.
        clearLog();
        driveTuple(1'b1, 6'h2A, 5'd0, 5'd0, 3'd0, 18'h12345, 1'b1);
        repeat (3) begin
            @(negedge clk);
            checkOutput("idle_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkOutput("idle_nwrites", wAddr.size(), 0);

        // One-word R-format session.
        startSession(8'h10);
        applyStimulus(1'b0, 6'h01, 5'd3, 5'd4, 3'd2, 18'h3FFFF, 1'b1);
        waitDone();
        expA[0] = 8'h10; expD[0] = 24'h046402;
        checkSession("rfmt", 1);

        // J-format, R fields set to non-zero junk.
        startSession(8'h20);
        applyStimulus(1'b1, 6'h3F, 5'd31, 5'd31, 3'd7, 18'h00ABC, 1'b1);
        waitDone();
        expA[0] = 8'h20; expD[0] = 24'hFC0ABC;
        checkSession("jfmt", 1);

        // Backpressure: memory busy while five tuples are offered.
        startSession(8'h40);
        mem_busy = 1'b1;
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, 6'h10 + 6'(k), 5'd0, 5'd0, 3'd0, 18'h00100 + 18'(k), 1'b0);
        driveTuple(1'b1, 6'h14, 5'd0, 5'd0, 3'd0, 18'h00104, 1'b1);
        repeat (2) begin
            @(negedge clk);
            checkOutput("busy_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        checkOutput("busy_nwrites", wAddr.size(), 0);
        mem_busy = 1'b0;
        applyStimulus(1'b1, 6'h14, 5'd0, 5'd0, 3'd0, 18'h00104, 1'b1);
        waitDone();
        expA[0] = 8'h40; expD[0] = 24'h400100;
        expA[1] = 8'h41; expD[1] = 24'h440101;
        expA[2] = 8'h42; expD[2] = 24'h480102;
        expA[3] = 8'h43; expD[3] = 24'h4C0103;
        expA[4] = 8'h44; expD[4] = 24'h500104;
        checkSession("busy", 5);

        // Address wrap at the top of memory, exercising R field positions.
        startSession(8'hFE);
        applyStimulus(1'b0, 6'h02, 5'd1, 5'd2, 3'd7, 18'h0, 1'b0);
        applyStimulus(1'b0, 6'h3F, 5'd31, 5'd0, 3'd0, 18'h0, 1'b0);
        applyStimulus(1'b0, 6'h00, 5'd0, 5'd31, 3'd5, 18'h0, 1'b1);
        waitDone();
        expA[0] = 8'hFE; expD[0] = 24'h082207;
        expA[1] = 8'hFF; expD[1] = 24'hFFE000;
        expA[2] = 8'h00; expD[2] = 24'h001F05;
        checkSession("wrap", 3);

        // A start pulse during RUN must not reload the address.
        startSession(8'h60);
        applyStimulus(1'b1, 6'h01, 5'd0, 5'd0, 3'd0, 18'h00001, 1'b0);
        start = 1'b1;
        base_addr = 8'h80;
        @(posedge clk);
        #1;
        start = 1'b0;
        applyStimulus(1'b1, 6'h02, 5'd0, 5'd0, 3'd0, 18'h00002, 1'b1);
        waitDone();
        expA[0] = 8'h60; expD[0] = 24'h040001;
        expA[1] = 8'h61; expD[1] = 24'h080002;
        checkSession("restart", 2);

        // Mid-session reset with two words buffered; busy drops simultaneously.
        startSession(8'h70);
        mem_busy = 1'b1;
        applyStimulus(1'b1, 6'h05, 5'd0, 5'd0, 3'd0, 18'h00005, 1'b0);
        applyStimulus(1'b1, 6'h06, 5'd0, 5'd0, 3'd0, 18'h00006, 1'b0);
        #2;
        mem_busy = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_imem_we", imem_we, 0);
        checkOutput("midrst_in_ready", in_ready, 0);
        checkOutput("midrst_count", count, 0);
        clearLog();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("postrst_nwrites", wAddr.size(), 0);
        checkOutput("postrst_in_ready", in_ready, 0);

        startSession(8'h30);
        applyStimulus(1'b0, 6'h01, 5'd3, 5'd4, 3'd2, 18'h0, 1'b1);
        waitDone();
        expA[0] = 8'h30; expD[0] = 24'h046402;
        checkSession("afterrst", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_packer.md
INST_PACKER -- requirements
Module: inst_packer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, holding FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter AW, default 8, giving the instruction-memory address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle pulse that begins a load session.
REQ-006 base_addr  input  AW  first memory address written, sampled on start.
REQ-007 in_valid  input  1  field tuple valid.
REQ-008 in_ready  output  1  packer can accept a tuple this cycle.
REQ-009 in_last  input  1  marks the final tuple of the session, qualified by in_valid.
REQ-010 jfmt  input  1  1 = J-format, 0 = R-format.
REQ-011 opc  input  6  opcode.
REQ-012 rs  input  5  source register.
REQ-013 rt  input  5  target register.
REQ-014 funcode  input  3  function code.
REQ-015 jba  input  18  jump/branch address.
REQ-016 mem_busy  input  1  instruction memory cannot take a write this cycle.
REQ-017 imem_we  output  1  write strobe.
REQ-018 imem_addr  output  AW  write address.
REQ-019 imem_wdata  output  24  packed instruction.
REQ-020 done  output  1  one-cycle pulse at session end.
REQ-021 count  output  AW+1  words written in the current/last session.

Function
REQ-022 R-format packing SHALL be {opc, rs, rt, 5'b0, funcode}: opc [23:18], rs [17:13], rt [12:8], [7:3] zero, funcode [2:0].
REQ-023 J-format packing SHALL be {opc, jba}; rs, rt and funcode ignored.
REQ-024 FSM states SHALL be IDLE, RUN, DRAIN.
- IDLE -> RUN on start.
- RUN -> DRAIN on an accepted tuple with in_last=1.
- DRAIN -> IDLE once FIFO empty and no write pending; done pulses in the cycle the last write is issued.
REQ-025 A tuple SHALL be accepted when in_valid && in_ready.
- in_ready = (state==RUN) && !full.
- in_ready SHALL NOT depend on a same-cycle pop.
REQ-026 An accepted tuple SHALL be packed and pushed into the FIFO at that edge.
REQ-027 Writer SHALL issue imem_we=1 from the FIFO head in any cycle where FIFO is non-empty and mem_busy=0, popping the head that cycle; minimum latency from accept edge to imem_we is one cycle.
REQ-028 imem_we, imem_addr and imem_wdata SHALL be combinational from FIFO head and address counter.
REQ-029 Address counter SHALL load base_addr on start and increment by 1 per write, wrapping 2^AW-1 -> 0 silently.
REQ-030 count SHALL clear on start and increment per write; it holds after done until the next start.
REQ-031 Simultaneous push and pop SHALL keep occupancy unchanged with both completing.
REQ-032 start outside IDLE SHALL be ignored.
REQ-033 in_valid outside RUN SHALL be ignored; no tuple is lost because in_ready is 0.
REQ-034 Writes SHALL continue in DRAIN under mem_busy stalls.
REQ-035 Words SHALL be written in acceptance order.
REQ-036 start with in_last on the first tuple SHALL produce a one-word session.

Reset
REQ-037 rst_n low SHALL immediately clear:
- state=IDLE;
- FIFO empty, pointers 0;
- address counter 0, count 0;
- in_ready=0, imem_we=0, done=0.
REQ-038 Reset mid-session SHALL discard buffered words with no further writes.
REQ-039 After rst_n rises, the block SHALL wait in IDLE for start.

Verification
REQ-040 start, base_addr=8'h10; R tuple opc=6'h01, rs=3, rt=4, funcode=2, in_last=1 -> one write, imem_addr=8'h10, imem_wdata=24'h046402, done pulse, count=1.
REQ-041 J tuple opc=6'h3F, jba=18'h00ABC -> imem_wdata=24'hFC0ABC, rs/rt/funcode values irrelevant.
REQ-042 mem_busy=1 held while 5 tuples are offered:
- in_ready drops after 4 accepts;
- release mem_busy -> 5 writes in order at consecutive addresses.
REQ-043 base_addr=8'hFE, 3 tuples -> addresses FE, FF, 00; count=3.
REQ-044 rst_n asserted with 2 words buffered -> imem_we=0 immediately; no writes until next start.
REQ-045 start pulsed in RUN -> ignored; address sequence unaffected.
